// File: rtl/regfile_wb_port.sv
// regfile_wb_port: MIPS32 register file fed by WriteBack, with optional same-cycle bypass (REGFILE_BYPASS_EN)
module regfile_wb_port #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_a_rst,
  input  logic              i_s_rst,
  input  logic              i_we,
  input  logic [31:0]       i_instr_WrBc,
  input  logic [DATA_W-1:0] i_Mem_out_WrBc,
  input  logic [4:0]        i_rs_addr,
  input  logic [4:0]        i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic              o_wr_valid,
  output logic [4:0]        o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [CNT_W-1:0]  o_retire_cnt
);
`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif
  logic [DATA_W-1:0] regs [32];
  logic [5:0] op;
  logic [4:0] dest;
  logic wen, commit, unused;
  assign op = i_instr_WrBc[31:26];
  assign unused = ^{i_instr_WrBc[25:21], i_instr_WrBc[10:6]};
  // decode destination and whether this instruction writes a register
  always_comb begin
    dest = op == 6'h00 ? i_instr_WrBc[15:11] : op == 6'h03 ? 5'd31 : i_instr_WrBc[20:16];
    wen = (op == 6'h00 && i_instr_WrBc[5:0] != 6'h08) || op == 6'h23 || op[5:3] == 3'b001 || op == 6'h03;
    commit = i_we && wen && dest != 5'd0;
  end
  // combinational read ports; register 0 is hardwired to zero
  always_comb begin
    o_rs_data = i_rs_addr == 5'd0 ? '0 : (Bypass && commit && dest == i_rs_addr) ? i_Mem_out_WrBc : regs[i_rs_addr];
    o_rt_data = i_rt_addr == 5'd0 ? '0 : (Bypass && commit && dest == i_rt_addr) ? i_Mem_out_WrBc : regs[i_rt_addr];
  end
  // commit the WriteBack result, echo it and count retired writes
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst || i_s_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      o_wr_valid   <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_retire_cnt <= '0;
    end else begin
      o_wr_valid <= commit;
      if (commit) begin
        regs[dest]   <= i_Mem_out_WrBc;
        o_wr_addr    <= dest;
        o_wr_data    <= i_Mem_out_WrBc;
        o_retire_cnt <= o_retire_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/regfile_wb_port.md
Name: regfile_wb_port

Overview:
- Architectural register file for the MIPS32 pipeline. It is the consuming end of the WriteBack pipe register.
- Takes the instruction word and result word latched by WriteBack, decodes the destination register, and commits the result on the clock edge.
- Serves the Decode stage through two combinational read ports, with optional same-cycle write-to-read bypass.
- Also keeps a retired-write counter and a registered echo of the last commit, used for forwarding and debug.

Parameters:
- DATA_W, 32, register and data width.
- CNT_W, 32, width of the retired-write counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_a_rst  in  1  asynchronous reset, active-high.
- i_s_rst  in  1  synchronous clear, same effect as i_a_rst but applied at the clock edge.
- i_we  in  1  the WriteBack slot is valid this cycle; 0 means bubble or stall.
- i_instr_WrBc  in  32  instruction word leaving WriteBack.
- i_Mem_out_WrBc  in  DATA_W  result word leaving WriteBack.
- i_rs_addr  in  5  read port A address.
- i_rt_addr  in  5  read port B address.
- o_rs_data  out  DATA_W  read port A data, combinational.
- o_rt_data  out  DATA_W  read port B data, combinational.
- o_wr_valid  out  1  a commit happened on the previous edge (registered).
- o_wr_addr  out  5  destination of that commit (registered).
- o_wr_data  out  DATA_W  data of that commit (registered).
- o_retire_cnt  out  CNT_W  count of committed writes.

Behaviour:
- Reset (async i_a_rst or sync i_s_rst):
  - all 32 registers go to 0.
  - o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_retire_cnt=0.
  - i_a_rst takes effect immediately, without waiting for a clock edge.
  - A write in flight on the reset cycle is dropped.
- Destination decode is combinational from i_instr_WrBc, using opcode = [31:26]:
  - 000000 (R-type): dest = [15:11]; writes unless funct [5:0] = 001000 (JR).
  - 100011 (LW), 001000 (ADDI), 001001 (ADDIU), 001010 (SLTI), 001011 (SLTIU), 001100 (ANDI), 001101 (ORI), 001110 (XORI), 001111 (LUI): dest = [20:16].
  - 000011 (JAL): dest = 31.
  - All other opcodes (SW, branches, J, unknown): no write.
- Commit condition: i_we=1, the opcode is a writing opcode, and dest != 0.
- On a commit at the edge:
  - reg[dest] <= i_Mem_out_WrBc.
  - o_wr_valid<=1, o_wr_addr<=dest, o_wr_data<=i_Mem_out_WrBc.
  - o_retire_cnt increments by 1.
- Retire counter wraps from 2^CNT_W-1 to 0 with no flag.
- With no commit at the edge:
  - o_wr_valid<=0; o_wr_addr and o_wr_data hold their values.
  - o_retire_cnt holds.
- Register 0:
  - never written; always reads 0.
  - a write targeting 0 is not counted and leaves o_wr_valid=0.
- Reads are combinational: o_rs_data = reg[i_rs_addr] and o_rt_data = reg[i_rt_addr], zero latency, subject to bypass per the feature below.
- Both ports may read the same address simultaneously and return the same value.
- A write becomes visible through the array on the cycle after its commit edge.
- i_we=0 fully suppresses writes, regardless of the instruction word (bubbles may carry stale instructions).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port returns i_Mem_out_WrBc combinationally when its address equals the current-cycle commit dest and the commit condition is true.
  - Address 0 is never bypassed and still returns 0.
  - Gives write-before-read semantics within a cycle.
- Undefined:
  - Reads always return the array contents, so the old value is seen in the commit cycle.
  - The pipeline must resolve this hazard externally.

Test Plan:
- Reset: assert i_a_rst mid-cycle after writing reg5=0xDEADBEEF → all reads 0, o_retire_cnt=0, o_wr_valid=0, immediately without a clock edge.
- R-type write: i_we=1, instr=0x00A63820 (ADD rd=7), data=0x12345678 → next cycle reg7 reads 0x12345678, o_wr_addr=7, o_retire_cnt=1.
- LW/JAL/LUI decode:
  - LW instr=0x8C890004 (rt=9), data=0x55 → reg9=0x55.
  - JAL instr=0x0C000010, data=0x400008 → reg31=0x400008.
  - SW instr=0xAC890004 → no write, counter unchanged.
- Zero register and stall:
  - ADDI to rt=0 with data 0xFFFF → reg0 reads 0, counter unchanged.
  - i_we=0 with LW instr → no change, o_wr_valid=0.
- Same-cycle hazard: commit reg3=0xA5A5A5A5 while i_rs_addr=3 and i_rt_addr=3, previous value 0x1 → with REGFILE_BYPASS_EN both ports read 0xA5A5A5A5 that cycle; without it both read 0x1, then 0xA5A5A5A5 next cycle.
- Counter wrap and sync clear:
  - CNT_W=4, 16 commits → o_retire_cnt wraps 15→0.
  - Then pulse i_s_rst concurrent with a commit to reg4 → reg4=0, counter=0, o_wr_valid=0 after the edge.
